// File: rtl/result_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : result_stream_reader
// Sweeps a contiguous row range of the result BRAM and returns each row as a
// valid/ready stream, hiding BRAM read latency behind a credit-limited FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module result_stream_reader #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            length,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          bram_r_r_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
  output logic [PE_COUNT*DATA_WIDTH-1:0] m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast
);
  localparam int ROW_W = PE_COUNT * DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(BRAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]        CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0]      infl_q, infl_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [RD_LATENCY:0]   tag_q, last_q;
  logic [ROW_W-1:0]      fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PTR_W-1:0]      wr_q, rd_q;
  logic                  issue, issue_last, capture, pop, credit_ok;

  // Rows already in the FIFO plus rows still in the BRAM pipe must fit.
  assign credit_ok = ({1'b0, count_q} + {1'b0, infl_q}) < CREDITS;
  assign capture   = tag_q[RD_LATENCY];
  assign pop       = m_tvalid & m_tready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = S_DONE;
          end else begin
            // The first read goes out on the accepting edge itself.
            issue      = 1'b1;
            issue_last = (length == LEN_ONE);
            addr_d     = base_addr;
            rem_d      = length - LEN_ONE;
            state_d    = (length == LEN_ONE) ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (rem_q == LEN_ONE);
          addr_d     = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
          rem_d      = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && m_tlast) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    infl_d = infl_q;
    case ({issue, capture})
      2'b10:   infl_d = infl_q + CNT_ONE;
      2'b01:   infl_d = infl_q - CNT_ONE;
      default: infl_d = infl_q;
    endcase
    count_d = count_q;
    case ({capture, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Tag stage 0 lines up with the cycle the issued address is on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      infl_q  <= '0;
      tag_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      infl_q  <= infl_d;
      tag_q   <= {tag_q[RD_LATENCY-1:0], issue};
      last_q  <= {last_q[RD_LATENCY-1:0], issue_last};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
      fifo_last_q <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
    end else begin
      if (capture) begin
        fifo_data_q[wr_q] <= bram_r_r_data;
        fifo_last_q[wr_q] <= last_q[RD_LATENCY];
        wr_q              <= wr_q + PTR_ONE;
      end
      if (pop) rd_q <= rd_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign bram_r_r_addr = addr_q;
  assign m_tvalid      = (count_q != '0);
  assign m_tdata       = fifo_data_q[rd_q];
  assign m_tlast       = m_tvalid & fifo_last_q[rd_q];

endmodule
`default_nettype wire

// File: tb/tb_result_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_stream_reader
// Self-checking bench: BRAM model, queue-based row scoreboard, timing table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_stream_reader;
  localparam int PE_COUNT   = 4;
  localparam int DATA_WIDTH = 32;
  localparam int BRAM_DEPTH = 1024;
  localparam int ADDR_WIDTH = 10;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int ROW_W      = PE_COUNT * DATA_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  m_tready = 1'b1;
  logic [ADDR_WIDTH-1:0] base_addr = '0;
  logic [ADDR_WIDTH:0]   length = '0;
  logic                  busy, done, m_tvalid, m_tlast;
  logic [ADDR_WIDTH-1:0] bram_r_r_addr;
  logic [ROW_W-1:0]      bram_r_r_data, m_tdata;

  always #5 clk = ~clk;

  result_stream_reader #(
    .PE_COUNT(PE_COUNT), .DATA_WIDTH(DATA_WIDTH), .BRAM_DEPTH(BRAM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH), .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .bram_r_r_addr(bram_r_r_addr),
    .bram_r_r_data(bram_r_r_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast)
  );

  // Result BRAM: data appears two cycles after the address.
  logic [ROW_W-1:0] mem [BRAM_DEPTH];
  logic [ROW_W-1:0] rd_s1, rd_s2;
  always @(posedge clk) begin
    rd_s1 <= mem[bram_r_r_addr];
    rd_s2 <= rd_s1;
  end
  assign bram_r_r_data = rd_s2;

  typedef struct packed { logic last; logic [ROW_W-1:0] data; } beat_t;
  typedef struct { int base; int len; int first; int last; int done_c; } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[5];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, t0 = 0, rdy_mode = 0;
  int beats, lasts, first_rel, last_rel, done_cnt, done_rel;
  logic stall_prev = 1'b0;
  logic [ROW_W:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_row(input string name, input logic [ROW_W:0] act, input logic [ROW_W:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_stats();
    beats = 0; lasts = 0; first_rel = -1; last_rel = -1; done_cnt = 0; done_rel = -1;
  endtask

  // Ready pattern: 0 = always high, 1 = random 50%, 2 = low in cycles 5..20.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = !((cyc - t0) >= 5 && (cyc - t0) <= 20);
      endcase
    end
  end

  // Scoreboard: every handshake must match the next expected row.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk_int("hold_tvalid", int'(m_tvalid), 1);
        chk_row("hold_beat", {m_tlast, m_tdata}, held);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got row %0h, expected no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk_row("beat", {m_tlast, m_tdata}, {e.last, e.data});
        end
        beats++;
        if (first_rel < 0) first_rel = cyc - t0;
        last_rel = cyc - t0;
        if (m_tlast) lasts++;
      end
      stall_prev = m_tvalid && !m_tready;
      held       = {m_tlast, m_tdata};
      if (done) begin
        done_cnt++;
        done_rel = cyc - t0;
      end
    end
  end

  // Runs one transfer; poke_cyc pulses a foreign start (base 0, len 5).
  task automatic run_xfer(input int base, input int len, input int mode, input int poke_cyc);
    int c;
    clear_stats();
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), mem[(base + i) % BRAM_DEPTH]});
    rdy_mode  = mode;
    t0        = cyc;
    start     = 1'b1;
    base_addr = ADDR_WIDTH'(base);
    length    = (ADDR_WIDTH + 1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (done_cnt == 0 && c < len * 8 + 200) begin
      if (c == poke_cyc) begin
        start = 1'b1; base_addr = '0; length = (ADDR_WIDTH + 1)'(5);
      end else begin
        start = 1'b0;
      end
      if (c == 1 && len > 0) chk_int("busy_after_start", int'(busy), 1);
      if (mode == 2 && c == 20) begin
        chk_int("bp_beats", beats, 1);
        chk_int("bp_addr", int'(bram_r_r_addr), (base + FIFO_DEPTH) % BRAM_DEPTH);
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk_int("beats", beats, len);
    chk_int("tlast_count", lasts, (len > 0) ? 1 : 0);
    chk_int("done_pulses", done_cnt, 1);
    chk_int("rows_left", exp_q.size(), 0);
    chk_int("busy_after_done", int'(busy), 0);
    if (len > 0) chk_int("last_addr", int'(bram_r_r_addr), (base + len - 1) % BRAM_DEPTH);
    exp_q.delete();
  endtask

  initial begin
    int a_before, rbase;
    vecs[0] = '{base: 0,    len: 10,   first: 4,  last: 13,   done_c: 14};
    vecs[1] = '{base: 1022, len: 4,    first: 4,  last: 7,    done_c: 8};
    vecs[2] = '{base: 500,  len: 1,    first: 4,  last: 4,    done_c: 5};
    vecs[3] = '{base: 7,    len: 0,    first: -1, last: -1,   done_c: 1};
    vecs[4] = '{base: 100,  len: 1024, first: 4,  last: 1027, done_c: 1028};
    for (int r = 0; r < BRAM_DEPTH; r++)
      for (int k = 0; k < PE_COUNT; k++)
        mem[r][k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(10 * r + k);

    repeat (2) @(posedge clk); #1;
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_done", int'(done), 0);
    chk_int("rst_tvalid", int'(m_tvalid), 0);
    chk_int("rst_tlast", int'(m_tlast), 0);
    chk_row("rst_tdata", {1'b0, m_tdata}, '0);
    chk_int("rst_addr", int'(bram_r_r_addr), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      a_before = int'(bram_r_r_addr);
      run_xfer(vecs[v].base, vecs[v].len, 0, -1);
      chk_int("first_beat_cycle", first_rel, vecs[v].first);
      chk_int("last_beat_cycle", last_rel, vecs[v].last);
      chk_int("done_cycle", done_rel, vecs[v].done_c);
      if (vecs[v].len == 0) chk_int("len0_addr_held", int'(bram_r_r_addr), a_before);
    end

    run_xfer(200, 16, 2, -1);

    rbase = int'($urandom_range(0, BRAM_DEPTH - 1));
    for (int i = 0; i < 100; i++)
      for (int k = 0; k < PE_COUNT; k++)
        mem[(rbase + i) % BRAM_DEPTH][k*DATA_WIDTH +: DATA_WIDTH] =
          (k % 2 == 0) ? DATA_WIDTH'(-5 - int'($urandom_range(0, 1000))) : DATA_WIDTH'($urandom);
    run_xfer(rbase, 100, 1, -1);

    run_xfer(300, 20, 0, 8);
    run_xfer(40, 20, 0, 24);

    // Reset in the cycle of the third beat aborts the transfer outright.
    clear_stats();
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), mem[i]});
    t0 = cyc; start = 1'b1; base_addr = '0; length = (ADDR_WIDTH + 1)'(10);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk_int("abort_tvalid", int'(m_tvalid), 0);
    chk_int("abort_busy", int'(busy), 0);
    chk_int("abort_tlast", int'(m_tlast), 0);
    chk_row("abort_tdata", {1'b0, m_tdata}, '0);
    chk_int("abort_beats", beats, 2);
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_int("abort_no_done", done_cnt, 0);
    run_xfer(0, 2, 0, -1);
    chk_int("post_rst_first", first_rel, 4);
    chk_int("post_rst_done", done_rel, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
